// File: rtl/uart_tx_scheduler_if.sv
// uart_tx_scheduler_if
//   Bundles the requester side and the uart side of the transmit scheduler.
//   master : the scheduler (drives gnt and the uart controls, reads req/tx_busy)
//   slave  : the environment (requesters + uart), drives req/req_data/req_baud/tx_busy
//   Signals:
//     req[N_REQ]          per-requester level request
//     req_data[8*N_REQ]   byte for requester i at [8i+7:8i]
//     req_baud[3*N_REQ]   baud select for requester i at [3i+2:3i]
//     gnt[N_REQ]          one-hot capture pulse
//     tx_en, tx_wr        uart enable / one-cycle write strobe
//     tx_data, baud_sel   byte and baud presented to the uart
//     tx_busy             uart transmitter busy
//     active_id           requester currently being served
//     sched_busy          scheduler not idle
//     err_timeout         one-cycle pulse when the uart never took a write
interface uart_tx_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_data;
  logic [3*N_REQ-1:0] req_baud;
  logic [N_REQ-1:0]   gnt;
  logic               tx_en;
  logic               tx_wr;
  logic [7:0]         tx_data;
  logic [2:0]         baud_sel;
  logic               tx_busy;
  logic [ID_W-1:0]    active_id;
  logic               sched_busy;
  logic               err_timeout;

  modport master (
    input  req, req_data, req_baud, tx_busy,
    output gnt, tx_en, tx_wr, tx_data, baud_sel, active_id, sched_busy, err_timeout
  );

  modport slave (
    output req, req_data, req_baud, tx_busy,
    input  gnt, tx_en, tx_wr, tx_data, baud_sel, active_id, sched_busy, err_timeout
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//   Shares one uart transmitter between N_REQ byte sources. Requests are
//   arbitrated round-robin; the winner's byte and baud select are captured in
//   IDLE and held until the next capture, so baud_sel only moves while the
//   transmitter is idle. A write the uart never acknowledges (tx_busy never
//   rises within ACK_TIMEOUT cycles) is dropped and flagged on err_timeout.
//   Ports:
//     clk   : clock, rising edge
//     reset : asynchronous active-low reset
//     bus   : uart_tx_scheduler_if.master (requesters + uart controls)
//   Timing (req sampled in IDLE at edge 0):
//     gnt/tx_data/baud_sel after edge 0, tx_en after edge 1, tx_wr after edge 2.
module uart_tx_scheduler #(
  parameter int N_REQ       = 4,
  parameter int ID_W        = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  uart_tx_scheduler_if.master bus
);

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WRITE,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [7:0]         data_q, data_d;
  logic [2:0]         baud_q, baud_d;
  logic               tx_en_q, tx_en_d;
  logic               tx_wr_q, tx_wr_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;

  logic               win_vld;
  logic [ID_W-1:0]    win_id;
  logic [7:0]         win_data;
  logic [2:0]         win_baud;

  // Round-robin search starting one past the last grant.
  always_comb begin : rr_pick
    int cand;
    int win_i;
    win_vld  = 1'b0;
    win_i    = 0;
    cand     = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = int'(last_q) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!win_vld && bus.req[ID_W'(cand)]) begin
        win_vld = 1'b1;
        win_i   = cand;
      end
    end
    win_id   = ID_W'(win_i);
    win_data = '0;
    win_baud = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (i == win_i) begin
        win_data = bus.req_data[8*i +: 8];
        win_baud = bus.req_baud[3*i +: 3];
      end
    end
  end

  always_comb begin : fsm_next
    state_d = state_q;
    gnt_d   = '0;
    data_d  = data_q;
    baud_d  = baud_q;
    id_d    = id_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    tx_wr_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = SETUP;
          gnt_d   = N_REQ'(1) << win_id;
          data_d  = win_data;
          baud_d  = win_baud;
          id_d    = win_id;
          last_d  = win_id;
        end
      end
      SETUP: state_d = WRITE;
      WRITE: begin
        state_d = WAIT_ACK;
        cnt_d   = '0;
        tx_wr_d = 1'b1;
      end
      WAIT_ACK: begin
        if (bus.tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT)) begin
          // Timeout already flagged on the previous edge; abandon the byte.
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          err_d = (cnt_d == CNT_W'(ACK_TIMEOUT));
        end
      end
      WAIT_DONE: begin
        if (!bus.tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // tx_en is registered from the next state so it rises one edge after
    // capture, leaving SETUP as the cycle where baud_sel settles with the
    // transmitter still disabled.
    tx_en_d = (state_d == WRITE) || (state_d == WAIT_ACK) || (state_d == WAIT_DONE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= ID_W'(N_REQ - 1);
      id_q    <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      data_q  <= 8'h00;
      baud_q  <= 3'b000;
      tx_en_q <= 1'b0;
      tx_wr_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      baud_q  <= baud_d;
      tx_en_q <= tx_en_d;
      tx_wr_q <= tx_wr_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.tx_en       = tx_en_q;
  assign bus.tx_wr       = tx_wr_q;
  assign bus.tx_data     = data_q;
  assign bus.baud_sel    = baud_q;
  assign bus.active_id   = id_q;
  assign bus.sched_busy  = busy_q;
  assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
module tb_uart_tx_scheduler;
  localparam int N_REQ       = 4;
  localparam int ID_W        = 2;
  localparam int ACK_TIMEOUT = 16;
  localparam int BUSY_LEN    = 10;

  logic clk = 1'b0;
  logic rst_n;

  uart_tx_scheduler_if #(.N_REQ(N_REQ), .ID_W(ID_W)) bus ();

  uart_tx_scheduler #(.N_REQ(N_REQ), .ID_W(ID_W), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // uart model: busy for BUSY_LEN cycles after each accepted write
  int   busy_cnt;
  logic uart_dead;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_cnt <= 0;
    else if (bus.tx_wr && !uart_dead) busy_cnt <= BUSY_LEN;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign bus.tx_busy = (busy_cnt != 0);

  typedef struct {
    int         id;
    logic [7:0] data;
    logic [2:0] baud;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   model_last;
  int   gnt_cnt[N_REQ];

  function automatic int rr_pick(input logic [3:0] r, input int last);
    int i;
    for (int k = 1; k <= 4; k++) begin
      i = (last + k) % 4;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic set_ch(input int ch, input logic [7:0] d, input logic [2:0] b);
    bus.req_data[8*ch +: 8] = d;
    bus.req_baud[3*ch +: 3] = b;
  endtask

  task automatic push_seq(input logic [3:0] r, input int n);
    exp_t e;
    int   p;
    for (int k = 0; k < n; k++) begin
      p      = rr_pick(r, model_last);
      e.id   = p;
      e.data = bus.req_data[8*p +: 8];
      e.baud = bus.req_baud[3*p +: 3];
      exp_q.push_back(e);
      model_last = p;
    end
  endtask

  task automatic wait_gnt(input int bound, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (bus.gnt != '0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (bus.sched_busy == 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n      = 1'b0;
    bus.req    = '0;
    uart_dead  = 1'b0;
    exp_q.delete();
    model_last = N_REQ - 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Scoreboard: grants and writes are matched against the expected queue.
  task automatic monitor();
    logic       prev_gnt;
    logic [3:0] exp_gnt;
    exp_t       e;
    prev_gnt = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin prev_gnt = 1'b0; continue; end
      if (bus.gnt != '0) begin
        for (int i = 0; i < N_REQ; i++) if (bus.gnt[i]) gnt_cnt[i]++;
        checks++;
        if (prev_gnt) begin
          errors++;
          $display("FAIL gnt_back_to_back got=%b required=idle cycle between grants", bus.gnt);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL gnt_unexpected got=%b required=no grant", bus.gnt);
        end else begin
          exp_gnt = 4'b0001 << exp_q[0].id;
          if (bus.gnt !== exp_gnt) begin
            errors++;
            $display("FAIL gnt_order got=%b required=%b", bus.gnt, exp_gnt);
          end
        end
      end
      prev_gnt = (bus.gnt != '0);
      if (bus.tx_wr === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tx_wr_unexpected got=write of %h required=no write", bus.tx_data);
        end else begin
          e = exp_q.pop_front();
          if ({bus.tx_data, bus.baud_sel, bus.active_id} !== {e.data, e.baud, ID_W'(e.id)}) begin
            errors++;
            $display("FAIL tx_write got=data %h baud %b id %0d required=data %h baud %b id %0d",
                     bus.tx_data, bus.baud_sel, bus.active_id, e.data, e.baud, e.id);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.gnt, bus.tx_en, bus.tx_wr, bus.err_timeout, bus.sched_busy} !== 8'b0) begin
      errors++;
      $display("FAIL reset_ctrl got=gnt %b en %b wr %b err %b busy %b required=all 0",
               bus.gnt, bus.tx_en, bus.tx_wr, bus.err_timeout, bus.sched_busy);
    end
    checks++;
    if ({bus.tx_data, bus.baud_sel, bus.active_id} !== 13'b0) begin
      errors++;
      $display("FAIL reset_data got=data %h baud %b id %0d required=00 000 0",
               bus.tx_data, bus.baud_sel, bus.active_id);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    bit ok;
    int busy_cycles;
    set_ch(0, 8'hAA, 3'b010);
    push_seq(4'b0001, 1);
    @(negedge clk);
    bus.req = 4'b0001;
    @(negedge clk);
    bus.req = '0;
    checks++;
    if (bus.gnt !== 4'b0001 || bus.tx_en !== 1'b0) begin
      errors++;
      $display("FAIL single_capture got=gnt %b en %b required=gnt 0001 en 0", bus.gnt, bus.tx_en);
    end
    busy_cycles = bus.sched_busy ? 1 : 0;
    @(negedge clk);
    busy_cycles += bus.sched_busy ? 1 : 0;
    checks++;
    if ({bus.gnt, bus.tx_en, bus.tx_wr} !== 6'b000010) begin
      errors++;
      $display("FAIL single_setup got=gnt %b en %b wr %b required=gnt 0000 en 1 wr 0", bus.gnt, bus.tx_en, bus.tx_wr);
    end
    @(negedge clk);
    busy_cycles += bus.sched_busy ? 1 : 0;
    checks++;
    if (bus.tx_wr !== 1'b1 || bus.tx_data !== 8'hAA || bus.baud_sel !== 3'b010) begin
      errors++;
      $display("FAIL single_write got=wr %b data %h baud %b required=wr 1 data aa baud 010", bus.tx_wr, bus.tx_data, bus.baud_sel);
    end
    @(negedge clk);
    busy_cycles += bus.sched_busy ? 1 : 0;
    checks++;
    if (bus.tx_wr !== 1'b0) begin
      errors++;
      $display("FAIL single_wr_pulse got=%b required=0", bus.tx_wr);
    end
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!bus.sched_busy) begin ok = 1'b1; break; end
      busy_cycles++;
    end
    checks++;
    if (!ok || busy_cycles != 4 + BUSY_LEN) begin
      errors++;
      $display("FAIL single_busy_len got=%0d (idle seen %0d) required=%0d", busy_cycles, ok, 4 + BUSY_LEN);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_queue got=%0d pending required=0", exp_q.size());
    end
  endtask

  task automatic test_alternate();
    bit ok;
    int n;
    apply_reset();
    set_ch(0, 8'h55, 3'b001);
    set_ch(2, 8'hCC, 3'b110);
    push_seq(4'b0101, 4);
    @(negedge clk);
    bus.req = 4'b0101;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.gnt != '0) n++;
      if (n == 4) begin bus.req = '0; break; end
    end
    wait_idle(40, ok);
    checks++;
    if (n != 4 || !ok) begin
      errors++;
      $display("FAIL alt_grants got=%0d grants idle %0d required=4 grants then idle", n, ok);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL alt_queue got=%0d pending required=0", exp_q.size());
    end
  endtask

  task automatic test_all_four();
    bit         ok;
    int         n;
    int         changes;
    logic [2:0] prev_baud;
    logic       prev_busy;
    apply_reset();
    set_ch(0, 8'h11, 3'b011);
    set_ch(1, 8'h22, 3'b101);
    set_ch(2, 8'h33, 3'b110);
    set_ch(3, 8'h44, 3'b111);
    push_seq(4'b1111, 5);
    @(negedge clk);
    prev_baud = bus.baud_sel;
    prev_busy = bus.sched_busy;
    bus.req   = 4'b1111;
    n         = 0;
    changes   = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bus.baud_sel !== prev_baud) begin
        changes++;
        checks++;
        if (prev_busy !== 1'b0 || bus.gnt == '0) begin
          errors++;
          $display("FAIL baud_hold got=%b->%b with prior busy %b required=change only on capture from idle",
                   prev_baud, bus.baud_sel, prev_busy);
        end
      end
      prev_baud = bus.baud_sel;
      prev_busy = bus.sched_busy;
      if (bus.gnt != '0) n++;
      if (n == 5) begin bus.req = '0; break; end
    end
    wait_idle(40, ok);
    checks++;
    if (n != 5 || changes != 5 || !ok) begin
      errors++;
      $display("FAIL rr4_grants got=%0d grants %0d baud changes required=5 and 5", n, changes);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rr4_queue got=%0d pending required=0", exp_q.size());
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int cyc;
    apply_reset();
    uart_dead = 1'b1;
    set_ch(1, 8'h3C, 3'b100);
    push_seq(4'b0010, 1);
    @(negedge clk);
    bus.req = 4'b0010;
    wait_gnt(10, ok);
    bus.req = '0;
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.tx_wr) begin ok = 1'b1; break; end
    end
    cyc = 0;
    for (int k = 0; k < 40 && ok; k++) begin
      @(negedge clk);
      cyc++;
      if (bus.err_timeout) break;
    end
    checks++;
    if (!ok || !bus.err_timeout || cyc != ACK_TIMEOUT) begin
      errors++;
      $display("FAIL timeout_delay got=%0d cycles (err %b) required=%0d", cyc, bus.err_timeout, ACK_TIMEOUT);
    end
    @(negedge clk);
    checks++;
    if (bus.err_timeout !== 1'b0 || bus.sched_busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_idle got=err %b busy %b required=err 0 busy 0", bus.err_timeout, bus.sched_busy);
    end
    uart_dead = 1'b0;
    set_ch(3, 8'h0F, 3'b111);
    push_seq(4'b1000, 1);
    bus.req = 4'b1000;
    wait_gnt(10, ok);
    bus.req = '0;
    wait_idle(40, ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      errors++;
      $display("FAIL timeout_recover got=idle %0d pending %0d required=idle 1 pending 0", ok, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    apply_reset();
    set_ch(2, 8'h77, 3'b011);
    push_seq(4'b0100, 1);
    @(negedge clk);
    bus.req = 4'b0100;
    wait_gnt(10, ok);
    bus.req = '0;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.tx_busy) begin ok = 1'b1; break; end
    end
    @(negedge clk);
    checks++;
    if (!ok || bus.sched_busy !== 1'b1 || bus.tx_en !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre got=busy seen %0d sched %b en %b required=1 1 1", ok, bus.sched_busy, bus.tx_en);
    end
    set_ch(0, 8'h89, 3'b101);
    bus.req = 4'b0101;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.gnt, bus.tx_en, bus.tx_wr, bus.err_timeout, bus.sched_busy} !== 8'b0) begin
      errors++;
      $display("FAIL midrst_ctrl got=gnt %b en %b wr %b err %b busy %b required=all 0",
               bus.gnt, bus.tx_en, bus.tx_wr, bus.err_timeout, bus.sched_busy);
    end
    checks++;
    if ({bus.tx_data, bus.baud_sel, bus.active_id} !== 13'b0) begin
      errors++;
      $display("FAIL midrst_data got=data %h baud %b id %0d required=00 000 0",
               bus.tx_data, bus.baud_sel, bus.active_id);
    end
    exp_q.delete();
    model_last = N_REQ - 1;
    push_seq(4'b0101, 1);
    @(negedge clk);
    rst_n = 1'b1;
    wait_gnt(10, ok);
    bus.req = '0;
    checks++;
    if (!ok || bus.gnt !== 4'b0001 || bus.tx_data !== 8'h89) begin
      errors++;
      $display("FAIL midrst_first got=gnt %b data %h required=gnt 0001 data 89", bus.gnt, bus.tx_data);
    end
    wait_idle(40, ok);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      errors++;
      $display("FAIL midrst_queue got=idle %0d pending %0d required=idle 1 pending 0", ok, exp_q.size());
    end
  endtask

  task automatic test_drop();
    bit ok;
    apply_reset();
    for (int i = 0; i < N_REQ; i++) gnt_cnt[i] = 0;
    set_ch(1, 8'h5A, 3'b010);
    push_seq(4'b0010, 1);
    @(negedge clk);
    bus.req = 4'b0010;
    wait_gnt(10, ok);
    @(negedge clk);
    bus.req = '0;
    wait_idle(40, ok);
    repeat (10) @(negedge clk);
    checks++;
    if (!ok || gnt_cnt[1] != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL drop_req got=ch1 grants %0d pending %0d required=1 grant 0 pending", gnt_cnt[1], exp_q.size());
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    uart_dead    = 1'b0;
    bus.req      = '0;
    bus.req_data = '0;
    bus.req_baud = '0;
    model_last   = N_REQ - 1;
    for (int i = 0; i < N_REQ; i++) gnt_cnt[i] = 0;
    fork
      monitor();
    join_none
    test_reset();
    test_single();
    test_alternate();
    test_all_four();
    test_timeout();
    test_reset_mid();
    test_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=simulation still running required=finish before limit");
    $fatal(1, "watchdog expired");
  end
endmodule
